hynoc_ingress_ctrl: RTL
=======================

# hynoc_ingress_ctrl

Ingress port packet controller of the hynoc router; sits directly upstream of `hynoc_ingress_routing_ucast` and downstream of the ingress flit FIFO. It pops the header flit and feeds it to the routing module. It latches the one-hot egress request and the updated header, holds the request until the egress arbiter grants it, then streams the header and all payload flits to the granted egress port. It releases the request after the tail flit.

## Interface
- `NB_PORTS`, 5, ports per router; egress request/grant width is `NB_PORTS-1`.
- `PAYLOAD_WIDTH`, 32, flit payload width.
- `FLIT_WIDTH`, `PAYLOAD_WIDTH+1`, flit width; bit `FLIT_WIDTH-1` is the tail flag (1 = last flit of packet).

Ports:
- `router_clk`  in  1  router clock, rising edge.
- `router_arst_n`  in  1  reset, asynchronous assert, active-low.
- `fifo_empty`  in  1  ingress FIFO empty.
- `fifo_rdata`  in  `FLIT_WIDTH`  show-ahead FIFO head; valid when `fifo_empty`=0.
- `fifo_read`  out  1  pop FIFO head this cycle.
- `route_rdata`  out  `FLIT_WIDTH`  flit to routing module; combinational copy of `fifo_rdata`.
- `route_request`  in  `NB_PORTS-1`  one-hot request from routing module.
- `route_header_write`  in  1  routing module: updated header valid (index ≠ 0).
- `route_header`  in  `FLIT_WIDTH`  routing module: header with decremented index.
- `to_egress_request`  out  `NB_PORTS-1`  registered one-hot request to egress arbiters.
- `from_egress_grant`  in  `NB_PORTS-1`  grants from egress arbiters.
- `from_egress_full`  in  1  granted egress buffer full; no write accepted.
- `to_egress_write`  out  1  flit write strobe to egress.
- `to_egress_data`  out  `FLIT_WIDTH`  flit to egress.

## Operation
- FSM states: IDLE, REQUEST, FORWARD. Reset: IDLE. All registers cleared: `to_egress_request`=0, header register=0, `hdr_pending`=0.
- Combinational outputs evaluate to 0 in reset/IDLE-empty: `fifo_read`, `to_egress_write`, `to_egress_data`.
- IDLE:
  - If `fifo_empty`=0: `fifo_read`=1 (header pop).
  - Latch `route_request` into the request register.
  - Latch the header register: `route_header` if `route_header_write`=1, else `fifo_rdata` unchanged.
  - Set `hdr_pending`=1; go to REQUEST.
- REQUEST:
  - `to_egress_request` = latched request.
  - When `|(from_egress_grant & request)`=1, go to FORWARD. Grants on other bits are ignored.
- FORWARD:
  - `to_egress_write` = `!from_egress_full & (hdr_pending | !fifo_empty)`.
  - `to_egress_data` = header register while `hdr_pending`, else `fifo_rdata`.
  - `fifo_read` = `to_egress_write & !hdr_pending`.
  - Header write clears `hdr_pending`.
  - Exit condition: a write whose flit has tail=1. The header qualifies when its own tail flag is set (single-flit packet).
  - On exit: clear the request register; go to IDLE.
- Request stays asserted through FORWARD; the egress arbiter holds the grant while the request is high.
- Empty FIFO in FORWARD: idle cycles allowed; no write; state held.

## Timing
- Header pop at cycle N. `to_egress_request` visible at N+1.
- Grant sampled at cycle M ≥ N+1. Header written at M+1 at the earliest.
- Payload: 1 flit/cycle when FIFO is non-empty and egress is not full.
- Tail written at cycle T. `to_egress_request`=0 at T+1, IDLE at T+1. Next header popped at T+1 at the earliest.
- `from_egress_full` is sampled combinationally in the write cycle. It has no effect outside FORWARD.
- Reset mid-packet:
  - Immediate return to IDLE; request drops asynchronously.
  - The partial packet is lost; upstream and egress are reset together.

## Structure
- Package `hynoc_pkg`: tail-bit index, FSM state enum. The `FLIT_PROTO_WIDTH` constant is shared with the routing module.
- No sub-module: `hynoc_ingress_routing_ucast` is instantiated beside this block at port level, not inside it.

## Test plan
- Single-flit packet, tail=1, index=2, hop[2]=3 → `fifo_read` one cycle; request=4'b1000 next cycle. After a grant on bit 3: one write with index=1, tail=1; request=0 the following cycle.
- 4-flit packet, grant on bit 1, `from_egress_full` high for 2 cycles mid-packet → no writes while full, no `fifo_read`; 4 writes total, in order.
- Header with index=0 → header forwarded unchanged (index 0, not 15).
- Request=4'b0100, grant driven on 4'b0010 for 5 cycles → stays in REQUEST, zero writes. Grant on bit 2 → FORWARD.
- Two back-to-back 2-flit packets in the FIFO → second header popped the cycle after the first tail. Request deasserted for at least 1 cycle in between.
- `router_arst_n` low during FORWARD after 1 payload flit → request, `to_egress_write` and `fifo_read` go to 0 immediately. After release: IDLE, and the next header is processed normally.

Source files
------------

// File: rtl/hynoc_pkg.sv
// hynoc_pkg
// Shared router constants and the ingress controller state encoding.
// FLIT_PROTO_WIDTH is the width of the routing fields at the bottom of a
// header flit: a 4-bit hop index followed by eight 2-bit hop entries. The
// routing module decodes these fields. The ingress controller only moves
// them around and never decodes them.
package hynoc_pkg;

  localparam int HYNOC_NB_PORTS      = 5;
  localparam int HYNOC_PAYLOAD_WIDTH = 32;
  localparam int HYNOC_FLIT_WIDTH    = HYNOC_PAYLOAD_WIDTH + 1;
  localparam int HYNOC_TAIL_BIT      = HYNOC_FLIT_WIDTH - 1;
  localparam int FLIT_PROTO_WIDTH    = 20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_FORWARD = 2'd2
  } ingress_state_e;

endpackage

// File: rtl/hynoc_ingress_ctrl.sv
// hynoc_ingress_ctrl
// Ingress packet controller. It pops a header flit from the show-ahead
// ingress FIFO and lets the routing module decode it. It latches the one-hot
// egress request and the (possibly rewritten) header. It holds the request
// until an egress arbiter grants it, then streams the header and the payload
// up to and including the tail flit to the granted egress port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a header at the FIFO head; pops it on arrival
// ST_REQUEST | request to the egress arbiters held, waiting for its grant
// ST_FORWARD | header, then payload, written to egress until the tail
//
// Ports:
//   router_clk, router_arst_n         clock, async active-low reset
//   fifo_empty, fifo_rdata, fifo_read ingress FIFO (show-ahead) interface
//   route_rdata                       FIFO head passed to the routing module
//   route_request, route_header_write,
//   route_header                      routing module decode results
//   to_egress_request                 registered one-hot request to arbiters
//   from_egress_grant                 grants from the egress arbiters
//   from_egress_full                  granted egress buffer cannot accept
//   to_egress_write, to_egress_data   flit write to the granted egress
module hynoc_ingress_ctrl
  import hynoc_pkg::*;
#(
  parameter int NB_PORTS      = HYNOC_NB_PORTS,
  parameter int PAYLOAD_WIDTH = HYNOC_PAYLOAD_WIDTH,
  parameter int FLIT_WIDTH    = PAYLOAD_WIDTH + 1
) (
  input  logic                  router_clk,
  input  logic                  router_arst_n,
  input  logic                  fifo_empty,
  input  logic [FLIT_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_read,
  output logic [FLIT_WIDTH-1:0] route_rdata,
  input  logic [NB_PORTS-2:0]   route_request,
  input  logic                  route_header_write,
  input  logic [FLIT_WIDTH-1:0] route_header,
  output logic [NB_PORTS-2:0]   to_egress_request,
  input  logic [NB_PORTS-2:0]   from_egress_grant,
  input  logic                  from_egress_full,
  output logic                  to_egress_write,
  output logic [FLIT_WIDTH-1:0] to_egress_data
);

  localparam int TAIL_IDX = FLIT_WIDTH - 1;

  ingress_state_e        state_q;
  logic [NB_PORTS-2:0]   request_q;
  logic [FLIT_WIDTH-1:0] header_q;
  logic                  hdr_pending_q;

  assign route_rdata       = fifo_rdata;
  assign to_egress_request = request_q;

  always_comb begin
    fifo_read       = 1'b0;
    to_egress_write = 1'b0;
    to_egress_data  = '0;
    case (state_q)
      ST_IDLE: begin
        fifo_read = !fifo_empty;
      end
      ST_FORWARD: begin
        to_egress_write = !from_egress_full && (hdr_pending_q || !fifo_empty);
        to_egress_data  = hdr_pending_q ? header_q : fifo_rdata;
        // The header has already been popped, so only payload writes pop.
        fifo_read       = to_egress_write && !hdr_pending_q;
      end
      default: ;
    endcase
    // While reset is held the state sits in IDLE. A non-empty FIFO must not
    // see a pop request during that time.
    if (!router_arst_n) begin
      fifo_read = 1'b0;
    end
  end

  always_ff @(posedge router_clk or negedge router_arst_n) begin
    if (!router_arst_n) begin
      state_q       <= ST_IDLE;
      request_q     <= '0;
      header_q      <= '0;
      hdr_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            request_q     <= route_request;
            // Index 0 means the routing module leaves the header unchanged.
            header_q      <= route_header_write ? route_header : fifo_rdata;
            hdr_pending_q <= 1'b1;
            state_q       <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          // Only a grant on the requested port counts.
          if (|(from_egress_grant & request_q)) begin
            state_q <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (to_egress_write) begin
            hdr_pending_q <= 1'b0;
            // A header with its own tail set is a complete single-flit packet.
            if (to_egress_data[TAIL_IDX]) begin
              request_q <= '0;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
